// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM issuing datapath controls for a multicycle MIPS subset
// Ports: clk/rst (sync, active-high); opcode/funct from IR; zero from ALU;
//   write strobes pc_write/ir_write/mem_read/mem_write/reg_write; selects i_or_d,
//   mem_to_reg, reg_dst, alu_src_a, alu_src_b[1:0], pc_src[1:0]; alu_ctrl[2:0];
//   instr_done/illegal_op pulses; state[3:0] for debug.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_ctrl,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3,
    MEM_WB = 4'd4, MEM_WRITE = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, BRANCH = 4'd8,
    JUMP = 4'd9, ADDI_EXEC = 4'd10, ADDI_WB = 4'd11;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
    ALU_SUB = 3'b110, ALU_SLT = 3'b111, ALU_OFF = 3'b100;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  logic [3:0] r_state, w_next;
  logic [2:0] w_funct_alu;
  logic       w_legal;
  assign state = r_state;
  assign w_funct_alu = funct == 6'b100000 ? ALU_ADD :
                       funct == 6'b100010 ? ALU_SUB :
                       funct == 6'b100100 ? ALU_AND :
                       funct == 6'b100101 ? ALU_OR  :
                       funct == 6'b101010 ? ALU_SLT : ALU_OFF;
  assign w_legal = opcode == OP_R || opcode == OP_LW || opcode == OP_SW ||
                   opcode == OP_BEQ || opcode == OP_J || opcode == OP_ADDI;
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:     w_next = DECODE;
      DECODE:    w_next = (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                          opcode == OP_R    ? R_EXEC :
                          opcode == OP_BEQ  ? BRANCH :
                          opcode == OP_J    ? JUMP   :
                          opcode == OP_ADDI ? ADDI_EXEC : FETCH;
      MEM_ADDR:  w_next = opcode == OP_LW ? MEM_READ : MEM_WRITE;
      MEM_READ:  w_next = MEM_WB;
      R_EXEC:    w_next = R_WB;
      ADDI_EXEC: w_next = ADDI_WB;
      default:   w_next = FETCH;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    i_or_d     = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_ctrl   = ALU_OFF;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        pc_write  = 1'b1;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        alu_ctrl   = ALU_ADD;
        illegal_op = !w_legal;
      end
      MEM_ADDR, ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = w_funct_alu;
      end
      R_WB: begin
        reg_write  = w_funct_alu != ALU_OFF;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_src     = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      i_or_d     = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      alu_ctrl   = ALU_OFF;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed plus random instruction stream checked against a spec-level model
module tb_multicycle_controller;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
    A_SUB = 3'b110, A_SLT = 3'b111, A_OFF = 3'b100;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, mem_to_reg, reg_dst,
        alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic [17:0] obs_v;
  int passed = 0, total = 0, fails = 0;
  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctrl(alu_ctrl),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );
  always #5 clk = ~clk;
  assign obs_v = {pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, mem_to_reg,
                  reg_dst, alu_src_a, alu_src_b, pc_src, alu_ctrl, instr_done, illegal_op};
  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return A_ADD;
      6'b100010: return A_SUB;
      6'b100100: return A_AND;
      6'b100101: return A_OR;
      6'b101010: return A_SLT;
      default:   return A_OFF;
    endcase
  endfunction
  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction
  function automatic logic [17:0] exp_out(input int st, input logic [5:0] op, fn, input logic z);
    logic pw, irw, mr, mw, rw, iod, m2r, rd, asa, dn, il;
    logic [1:0] asb, ps;
    logic [2:0] alu;
    {pw, irw, mr, mw, rw, iod, m2r, rd, asa, dn, il} = '0;
    asb = 2'b00;
    ps = 2'b00;
    alu = A_OFF;
    case (st)
      0: begin mr = 1; irw = 1; asb = 2'b01; alu = A_ADD; pw = 1; end
      1: begin asb = 2'b11; alu = A_ADD; il = !is_legal(op); end
      2, 10: begin asa = 1; asb = 2'b10; alu = A_ADD; end
      3: begin mr = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; dn = 1; end
      5: begin mw = 1; iod = 1; dn = 1; end
      6: begin asa = 1; alu = funct_alu(fn); end
      7: begin rw = funct_alu(fn) != A_OFF; rd = 1; dn = 1; end
      8: begin asa = 1; alu = A_SUB; ps = 2'b01; pw = z; dn = 1; end
      9: begin ps = 2'b10; pw = 1; dn = 1; end
      11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pw, irw, mr, mw, rw, iod, m2r, rd, asa, asb, ps, alu, dn, il};
  endfunction
  function automatic void path(input logic [5:0] op, output int q[$]);
    q = {0, 1};
    case (op)
      6'b100011: q = {q, 2, 3, 4};
      6'b101011: q = {q, 2, 5};
      6'b000000: q = {q, 6, 7};
      6'b000100: q = {q, 8};
      6'b000010: q = {q, 9};
      6'b001000: q = {q, 10, 11};
      default: ;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
    int q[$];
    int dones;
    path(op, q);
    opcode = op;
    funct = fn;
    dones = 0;
    foreach (q[k]) begin
      if (k > 0) @(negedge clk);
      zero = zmode == 2 ? 1'($urandom) : 1'(zmode);
      #1;
      chk($sformatf("op%b_state_k%0d", op, k), 32'(state), 32'(q[k]));
      chk($sformatf("op%b_fn%b_outs_st%0d", op, fn, q[k]), 32'(obs_v),
          32'(exp_out(q[k], op, fn, zero)));
      dones += int'(instr_done);
    end
    @(negedge clk);
    #1;
    chk($sformatf("op%b_return_fetch", op), 32'(state), 32'd0);
    chk($sformatf("op%b_done_count", op), 32'(dones), is_legal(op) ? 32'd1 : 32'd0);
  endtask
  initial begin
    logic [5:0] op, fn;
    int kind;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outs_gated", 32'(obs_v), {15'd0, A_OFF, 2'b00});
    rst = 1'b0;
    #1;
    chk("first_fetch_outs", 32'(obs_v), 32'(exp_out(0, 6'd0, 6'd0, 1'b0)));
    do_instr(6'b100011, 6'd0, 2);
    do_instr(6'b000000, 6'b101010, 2);
    do_instr(6'b000000, 6'b111111, 2);
    do_instr(6'b000100, 6'd0, 1);
    do_instr(6'b000100, 6'd0, 0);
    do_instr(6'b111111, 6'd0, 2);
    do_instr(6'b101011, 6'd0, 2);
    do_instr(6'b000010, 6'd0, 2);
    do_instr(6'b001000, 6'd0, 2);
    opcode = 6'b101011;
    zero = 1'b0;
    #1;
    chk("sw_rst_fetch", 32'(state), 32'd0);
    @(negedge clk);
    #1;
    chk("sw_rst_decode", 32'(state), 32'd1);
    @(negedge clk);
    #1;
    chk("sw_rst_memaddr", 32'(state), 32'd2);
    rst = 1'b1;
    #1;
    chk("sw_rst_gated_outs", 32'(obs_v), {15'd0, A_OFF, 2'b00});
    chk("sw_rst_state_hold", 32'(state), 32'd2);
    @(negedge clk);
    #1;
    chk("sw_rst_to_fetch", 32'(state), 32'd0);
    chk("sw_rst_outs_still_gated", 32'(obs_v), {15'd0, A_OFF, 2'b00});
    rst = 1'b0;
    #1;
    chk("sw_rst_release_fetch", 32'(obs_v), 32'(exp_out(0, 6'd0, 6'd0, 1'b0)));
    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 7));
      fn = 6'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 4))
          0: fn = 6'b100000;
          1: fn = 6'b100010;
          2: fn = 6'b100100;
          3: fn = 6'b100101;
          default: fn = 6'b101010;
        endcase
      end
      case (kind)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2, 3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b000010;
        6: op = 6'b001000;
        default: begin
          op = 6'($urandom);
          while (is_legal(op)) op = 6'($urandom);
        end
      endcase
      do_instr(op, fn, 2);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
